axi_mem_responder: RTL and testbench

- AXI4 slave (responder) that terminates one AXI interconnect master port and drives a single-port, word-wide SRAM with 1-cycle read latency.
- Serves as the data/instruction memory endpoint on the slave side of the AXI node, completing the initiator/responder pair.
- One transaction in flight at a time; INCR bursts only; full-width beats only.

---
 rtl/axi_mem_pkg.sv | 22 ++
 rtl/axi_mem_rd_buf.sv | 74 +++++++
 rtl/axi_mem_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi_mem_pkg
// Shared definitions for the AXI4 memory responder and its read buffer:
//   - AXI response codes
//   - responder FSM state type
//   - read buffer depth
// -----------------------------------------------------------------------------
package axi_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      WRESP,
      READ
   } state_t;

endpackage

// File: rtl/axi_mem_rd_buf.sv
// -----------------------------------------------------------------------------
// axi_mem_rd_buf
// Small FIFO holding SRAM read beats on their way to the AXI R channel.
// Each entry carries the data word plus last/resp sideband.
// Ports:
//   clk, rst_n                 clock, async active-low reset (empties buffer)
//   push, push_data/last/resp  write one entry (caller guarantees not full)
//   pop                        drop head entry (caller guarantees not empty)
//   count                      current occupancy
//   valid                      buffer not empty
//   head_data/last/resp        head entry contents
// -----------------------------------------------------------------------------
module axi_mem_rd_buf
   import axi_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1),
   localparam int unsigned PTR_W     = $clog2(BUF_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_last,
   input  logic [1:0]            push_resp,
   input  logic                  pop,
   output logic [CNT_W-1:0]      count,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_last,
   output logic [1:0]            head_resp
);

   logic [DATA_WIDTH-1:0] data_q [BUF_DEPTH];
   logic                  last_q [BUF_DEPTH];
   logic [1:0]            resp_q [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            data_q[i] <= '0;
            last_q[i] <= 1'b0;
            resp_q[i] <= RESP_OKAY;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= push_data;
            last_q[wr_ptr_q] <= push_last;
            resp_q[wr_ptr_q] <= push_resp;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign count     = count_q;
   assign valid     = (count_q != '0);
   assign head_data = data_q[rd_ptr_q];
   assign head_last = last_q[rd_ptr_q];
   assign head_resp = resp_q[rd_ptr_q];

endmodule

// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
// AXI4 slave terminating one interconnect port onto a single-port word SRAM
// with 1-cycle read latency. One transaction at a time, INCR bursts, full-width
// beats. Address bits [1:0] are ignored.
// Ports:
//   clk, rst_n          clock, async active-low reset (aborts any burst)
//   aw_* / w_* / b_*    AXI write address / data / response channels
//   ar_* / r_*          AXI read address / data channels
//   mem_*_o, mem_rdata_i SRAM interface (rdata valid the cycle after a read)
// Build option:
//   AXI_MEM_RANGE_CHECK_EN  beats addressing beyond the SRAM get no access and
//                           SLVERR; otherwise addresses alias modulo SRAM size.
// -----------------------------------------------------------------------------
module axi_mem_responder
   import axi_mem_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned MEM_ADDR_WIDTH = 12
) (
   input  logic                        clk,
   input  logic                        rst_n,
   // write address
   input  logic                        aw_valid,
   output logic                        aw_ready,
   input  logic [AXI_ID_WIDTH-1:0]     aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]                  aw_len,
   // write data
   input  logic                        w_valid,
   output logic                        w_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
   input  logic                        w_last,
   // write response
   output logic                        b_valid,
   input  logic                        b_ready,
   output logic [AXI_ID_WIDTH-1:0]     b_id,
   output logic [1:0]                  b_resp,
   // read address
   input  logic                        ar_valid,
   output logic                        ar_ready,
   input  logic [AXI_ID_WIDTH-1:0]     ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]                  ar_len,
   // read data
   output logic                        r_valid,
   input  logic                        r_ready,
   output logic [AXI_ID_WIDTH-1:0]     r_id,
   output logic [AXI_DATA_WIDTH-1:0]   r_data,
   output logic [1:0]                  r_resp,
   output logic                        r_last,
   // SRAM
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
   output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

   // With range checking the full word address is tracked so overflow past the
   // SRAM is visible; without it only the SRAM bits are kept and wrap naturally.
`ifdef AXI_MEM_RANGE_CHECK_EN
   localparam int unsigned WORD_AW = AXI_ADDR_WIDTH - 2;
`else
   localparam int unsigned WORD_AW = MEM_ADDR_WIDTH;
`endif

   state_t                    state_q, state_d;
   logic                      init_q;           // blocks AXI accepts during/just after reset
   logic                      last_grant_rd_q;  // 1: last accept was a read
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic [7:0]                len_q;
   logic [7:0]                beat_cnt_q;       // beats written / reads issued
   logic [WORD_AW-1:0]        addr_q;
   logic                      wr_err_q;
   logic                      issue_done_q;
   logic                      infl_q, infl_last_q, infl_err_q;

   logic                      aw_acc, ar_acc, w_hs, pop, rd_issue, space;
   logic                      last_beat, beat_oob;
   logic [1:0]                buf_count;
   logic                      buf_valid, buf_last;
   logic [1:0]                buf_resp;
   logic [AXI_DATA_WIDTH-1:0] buf_data;
   logic                      unused_addr;

   assign unused_addr = ^{aw_addr, ar_addr};

   // Arbitration: on simultaneous requests the channel not granted last wins.
   assign ar_ready = (state_q == IDLE) & init_q & (~aw_valid | ~last_grant_rd_q);
   assign aw_ready = (state_q == IDLE) & init_q & (~ar_valid | last_grant_rd_q);
   assign ar_acc   = ar_valid & ar_ready;
   assign aw_acc   = aw_valid & aw_ready;
   assign w_hs     = (state_q == WRITE) & w_valid;
   assign pop      = buf_valid & r_ready;

   assign last_beat = (beat_cnt_q == len_q);

`ifdef AXI_MEM_RANGE_CHECK_EN
   assign beat_oob = |addr_q[WORD_AW-1:MEM_ADDR_WIDTH];
`else
   assign beat_oob = 1'b0;
`endif

   // Keep buffered + in-flight beats within the buffer, counting this cycle's pop.
   assign space    = (({1'b0, buf_count} + {2'b00, infl_q}) - {2'b00, pop}) < 3'd2;
   assign rd_issue = (state_q == READ) & ~issue_done_q & space;

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ----------------------------------------------------------- FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (ar_acc) begin
               state_d = READ;
            end else if (aw_acc) begin
               state_d = WRITE;
            end
         end
         WRITE:   if (w_hs && last_beat) state_d = WRESP;
         WRESP:   if (b_ready) state_d = IDLE;
         READ:    if (pop && buf_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------- FSM outputs
   always_comb begin
      w_ready     = 1'b0;
      b_valid     = 1'b0;
      b_resp      = RESP_OKAY;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = addr_q[MEM_ADDR_WIDTH-1:0];
      mem_be_o    = '0;
      mem_wdata_o = '0;
      unique case (state_q)
         WRITE: begin
            w_ready = 1'b1;
            if (w_valid) begin
               mem_req_o   = ~beat_oob;
               mem_we_o    = ~beat_oob;
               mem_be_o    = w_strb;
               mem_wdata_o = w_data;
            end
         end
         WRESP: begin
            b_valid = 1'b1;
            b_resp  = wr_err_q ? RESP_SLVERR : RESP_OKAY;
         end
         READ:    mem_req_o = rd_issue & ~beat_oob;
         default: ;
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q          <= 1'b0;
         last_grant_rd_q <= 1'b0;
         id_q            <= '0;
         len_q           <= '0;
         beat_cnt_q      <= '0;
         addr_q          <= '0;
         wr_err_q        <= 1'b0;
         issue_done_q    <= 1'b0;
         infl_q          <= 1'b0;
         infl_last_q     <= 1'b0;
         infl_err_q      <= 1'b0;
      end else begin
         init_q <= 1'b1;
         if (aw_acc) begin
            last_grant_rd_q <= 1'b0;
            id_q            <= aw_id;
            len_q           <= aw_len;
            addr_q          <= aw_addr[WORD_AW+1:2];
            beat_cnt_q      <= '0;
            wr_err_q        <= 1'b0;
         end
         if (ar_acc) begin
            last_grant_rd_q <= 1'b1;
            id_q            <= ar_id;
            len_q           <= ar_len;
            addr_q          <= ar_addr[WORD_AW+1:2];
            beat_cnt_q      <= '0;
            issue_done_q    <= 1'b0;
         end
         if (w_hs) begin
            addr_q     <= addr_q + WORD_AW'(1);
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if ((w_last != last_beat) || beat_oob) begin
               wr_err_q <= 1'b1;
            end
         end
         if (rd_issue) begin
            addr_q       <= addr_q + WORD_AW'(1);
            beat_cnt_q   <= beat_cnt_q + 8'd1;
            issue_done_q <= last_beat;
         end
         // One-cycle pipe matching SRAM read latency.
         infl_q      <= rd_issue;
         infl_last_q <= last_beat;
         infl_err_q  <= beat_oob;
      end
   end

   axi_mem_rd_buf #(
      .DATA_WIDTH (AXI_DATA_WIDTH)
   ) u_rd_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (infl_q),
      .push_data (infl_err_q ? '0 : mem_rdata_i),
      .push_last (infl_last_q),
      .push_resp (infl_err_q ? RESP_SLVERR : RESP_OKAY),
      .pop       (pop),
      .count     (buf_count),
      .valid     (buf_valid),
      .head_data (buf_data),
      .head_last (buf_last),
      .head_resp (buf_resp)
   );

   assign b_id    = id_q;
   assign r_id    = id_q;
   assign r_valid = buf_valid;
   assign r_data  = buf_data;
   assign r_last  = buf_valid & buf_last;
   assign r_resp  = buf_valid ? buf_resp : RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_responder
// Directed bench for axi_mem_responder with a behavioural SRAM model.
// Honours AXI_MEM_RANGE_CHECK_EN for the out-of-range read expectations.
// -----------------------------------------------------------------------------
module tb_axi_mem_responder;

   logic        clk, rst_n;
   logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
   logic [3:0]  aw_id, b_id, ar_id, r_id, w_strb, mem_be_o;
   logic [31:0] aw_addr, ar_addr, w_data, r_data, mem_wdata_o, mem_rdata_i;
   logic [7:0]  aw_len, ar_len;
   logic [1:0]  b_resp, r_resp;
   logic        ar_valid, ar_ready, r_valid, r_ready, r_last, mem_req_o, mem_we_o;
   logic [11:0] mem_addr_o;

   int          n_pass, n_total;
   logic [31:0] wd [8];
   logic [31:0] ed [8];
   logic [1:0]  er [8];

   axi_mem_responder u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .aw_valid    (aw_valid),
      .aw_ready    (aw_ready),
      .aw_id       (aw_id),
      .aw_addr     (aw_addr),
      .aw_len      (aw_len),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .w_data      (w_data),
      .w_strb      (w_strb),
      .w_last      (w_last),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_id        (b_id),
      .b_resp      (b_resp),
      .ar_valid    (ar_valid),
      .ar_ready    (ar_ready),
      .ar_id       (ar_id),
      .ar_addr     (ar_addr),
      .ar_len      (ar_len),
      .r_valid     (r_valid),
      .r_ready     (r_ready),
      .r_id        (r_id),
      .r_data      (r_data),
      .r_resp      (r_resp),
      .r_last      (r_last),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_be_o    (mem_be_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model, preloaded with C0DE_0000 | word index.
   logic [31:0] mem [4096];
   bit          mem_init;
   int          rd_req_cnt, outstanding, max_outstanding;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
         mem_init <= 1'b1;
      end else if (mem_req_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= mem[mem_addr_o];
         end
      end
   end

   // Issued-but-not-returned read beats, to bound buffer + pipeline occupancy.
   always @(posedge clk) begin
      rd_req_cnt      <= rd_req_cnt + int'(mem_req_o && !mem_we_o);
      outstanding     <= outstanding + int'(mem_req_o && !mem_we_o) - int'(r_valid && r_ready);
      max_outstanding <= (outstanding > max_outstanding) ? outstanding : max_outstanding;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      bit got = 1'b0;
      @(negedge clk);
      aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (aw_ready) begin got = 1'b1; break; end
         @(negedge clk);
      end
      check("aw_accept", 32'(got), 1);
      @(posedge clk);
   endtask

   task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      bit got = 1'b0;
      @(negedge clk);
      ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (ar_ready) begin got = 1'b1; break; end
         @(negedge clk);
      end
      check("ar_accept", 32'(got), 1);
      @(posedge clk);
   endtask

   // Called right after the aw handshake edge; beat data comes from wd[].
   task automatic w_burst(input int n, input logic [11:0] ea, input logic [3:0] strb,
                          input logic [7:0] lm, input logic [1:0] eresp, input logic [3:0] eid);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         aw_valid = 1'b0; w_valid = 1'b1; w_data = wd[i]; w_strb = strb; w_last = lm[i];
         #1;
         check("w_ready", 32'(w_ready), 1);
         check("mem_req_wr", 32'(mem_req_o), 1);
         check("mem_we", 32'(mem_we_o), 1);
         check("mem_addr_wr", 32'(mem_addr_o), 32'(ea + 12'(i)));
         check("mem_be", 32'(mem_be_o), 32'(strb));
         check("mem_wdata", mem_wdata_o, wd[i]);
      end
      @(negedge clk);
      w_valid = 1'b0; w_last = 1'b0;
      #1;
      check("b_valid", 32'(b_valid), 1);
      check("b_resp", 32'(b_resp), 32'(eresp));
      check("b_id", 32'(b_id), 32'(eid));
      @(negedge clk);
      #1;
      check("b_done", 32'(b_valid), 0);
   endtask

   // Called right after the ar handshake edge; expected beats come from ed[]/er[].
   task automatic r_collect(input int n, input logic [3:0] eid, input logic [3:0] pat,
                            input bit tput);
      int          k = 0, first_v = -1, first_pop = 0, last_pop = 0;
      bit          stalled = 1'b0;
      logic [31:0] hold = '0;
      for (int c = 0; c < 60 && k < n; c++) begin
         @(negedge clk);
         ar_valid = 1'b0; r_ready = pat[c % 4];
         #1;
         if (stalled) begin
            check("r_hold_valid", 32'(r_valid), 1);
            check("r_hold_data", r_data, hold);
         end
         if (r_valid && first_v < 0) first_v = c;
         if (r_valid && r_ready) begin
            check("r_data", r_data, ed[k]);
            check("r_last", 32'(r_last), 32'(k == n - 1));
            check("r_resp", 32'(r_resp), 32'(er[k]));
            check("r_id", 32'(r_id), 32'(eid));
            if (k == 0) first_pop = c;
            last_pop = c;
            k++;
         end
         stalled = r_valid && !r_ready;
         hold    = r_data;
      end
      check("r_beats", 32'(k), 32'(n));
      check("r_first_valid", 32'(first_v), 2);
      if (tput) check("r_throughput", 32'(last_pop - first_pop), 32'(n - 1));
      @(posedge clk);
   endtask

   initial begin
      int rd_base;
      n_pass = 0; n_total = 0;
      rst_n = 1'b0;
      aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
      w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 1'b1;
      ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; r_ready = 0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst_aw_ready", 32'(aw_ready), 0);
      check("rst_ar_ready", 32'(ar_ready), 0);
      check("rst_w_ready", 32'(w_ready), 0);
      check("rst_b_valid", 32'(b_valid), 0);
      check("rst_r_valid", 32'(r_valid), 0);
      check("rst_mem_req", 32'(mem_req_o), 0);
      check("rst_mem_we", 32'(mem_we_o), 0);
      check("rst_resp_last", 32'({b_resp, r_resp, r_last}), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Simultaneous requests: read first, then write
      @(negedge clk);
      aw_valid = 1; aw_id = 4'h2; aw_addr = 32'h30; aw_len = 0;
      ar_valid = 1; ar_id = 4'h1; ar_addr = 32'h20; ar_len = 0;
      #1;
      check("arb1_ar_ready", 32'(ar_ready), 1);
      check("arb1_aw_ready", 32'(aw_ready), 0);
      @(posedge clk); #1;
      aw_valid = 0;
      ed[0] = 32'hC0DE_0008; er[0] = 2'b00;
      r_collect(1, 4'h1, 4'hF, 1'b0);
      @(negedge clk);
      aw_valid = 1; ar_valid = 1;
      #1;
      check("arb2_aw_ready", 32'(aw_ready), 1);
      check("arb2_ar_ready", 32'(ar_ready), 0);
      @(posedge clk); #1;
      ar_valid = 0;
      wd[0] = 32'h55;
      w_burst(1, 12'hC, 4'hF, 8'b1, 2'b00, 4'h2);

      // 4-beat write, then full-rate read back
      for (int i = 0; i < 4; i++) begin
         wd[i] = 32'hA0 + 32'(i); ed[i] = 32'hA0 + 32'(i); er[i] = 2'b00;
      end
      aw_hs(4'h5, 32'h10, 8'd3);
      w_burst(4, 12'h4, 4'hF, 8'b1000, 2'b00, 4'h5);
      ar_hs(4'h3, 32'h10, 8'd3);
      r_collect(4, 4'h3, 4'hF, 1'b1);

      // Same read with r_ready 1,0,0,1; low address bits ignored
      ar_hs(4'h6, 32'h12, 8'd3);
      r_collect(4, 4'h6, 4'b1001, 1'b0);
      check("max_outstanding", 32'(max_outstanding <= 2), 1);

      // w_last on first beat of a 2-beat burst -> SLVERR, both words written
      wd[0] = 32'hB0; wd[1] = 32'hB1;
      aw_hs(4'h7, 32'h100, 8'd1);
      w_burst(2, 12'h40, 4'hF, 8'b01, 2'b10, 4'h7);
      ed[0] = 32'hB0; ed[1] = 32'hB1; er[0] = 2'b00; er[1] = 2'b00;
      ar_hs(4'h7, 32'h100, 8'd1);
      r_collect(2, 4'h7, 4'hF, 1'b1);

      // Halfword strobe
      wd[0] = 32'h1234_5678;
      aw_hs(4'h8, 32'h200, 8'd0);
      w_burst(1, 12'h80, 4'h3, 8'b1, 2'b00, 4'h8);
      ed[0] = 32'hC0DE_5678; er[0] = 2'b00;
      ar_hs(4'h8, 32'h200, 8'd0);
      r_collect(1, 4'h8, 4'hF, 1'b0);

      // Read crossing the top of memory
      rd_base = rd_req_cnt;
      ed[0] = 32'hC0DE_0FFF; er[0] = 2'b00;
`ifdef AXI_MEM_RANGE_CHECK_EN
      ed[1] = 32'h0; er[1] = 2'b10;
`else
      ed[1] = 32'hC0DE_0000; er[1] = 2'b00;
`endif
      ar_hs(4'h9, 32'h3FFC, 8'd1);
      r_collect(2, 4'h9, 4'hF, 1'b1);
`ifdef AXI_MEM_RANGE_CHECK_EN
      check("range_mem_reqs", 32'(rd_req_cnt - rd_base), 1);
`else
      check("range_mem_reqs", 32'(rd_req_cnt - rd_base), 2);
`endif

      // Reset in the middle of a write burst: no response afterwards
      aw_hs(4'hA, 32'h400, 8'd3);
      @(negedge clk);
      aw_valid = 0; w_valid = 1; w_data = 32'hDEAD; w_strb = 4'hF; w_last = 0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_w_ready", 32'(w_ready), 0);
      check("midrst_mem_req", 32'(mem_req_o), 0);
      w_valid = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("midrst_b_valid", 32'(b_valid), 0);
      check("midrst_aw_ready", 32'(aw_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
